// File: rtl/trap_capture_pkg.sv
// Shared types and constants for the Z80 I/O trap capture block.
// TRAP_CAPTURE_DATA_EN adds the 8-bit write-data field to each FIFO entry.
package trap_capture_pkg;

  typedef enum logic [1:0] {StIdle, StCycle, StCommit} state_e;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_DATA    = 2'd3;

  localparam int unsigned FifoDepth = 2;
`ifdef TRAP_CAPTURE_DATA_EN
  localparam int unsigned EntryW = 25;
`else
  localparam int unsigned EntryW = 17;
`endif

endpackage

// File: rtl/trap_capture_if.sv
// Z80 bus plus hypervisor register port of the trap capture block.
interface trap_capture_if;
  logic        iorq_n;
  logic        m1_n;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        io_violation;
  logic        trap_state;
  logic        hv_rd;
  logic [1:0]  hv_sel;
  logic        hv_ack;
  logic [7:0]  hv_data;
  logic        pending;
  logic        overflow;

  modport master (
    output iorq_n, m1_n, rd_n, wr_n, addr, data, io_violation, trap_state,
    output hv_rd, hv_sel, hv_ack,
    input  hv_data, pending, overflow
  );

  modport slave (
    input  iorq_n, m1_n, rd_n, wr_n, addr, data, io_violation, trap_state,
    input  hv_rd, hv_sel, hv_ack,
    output hv_data, pending, overflow
  );
endinterface

// File: rtl/trap_fifo.sv
// Two-entry trap event FIFO with sticky overflow; pops on an empty FIFO are ignored.
module trap_fifo
  import trap_capture_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [EntryW-1:0] entry_i,
  input  logic              pop_i,
  output logic [EntryW-1:0] head_o,
  output logic [1:0]        count_o,
  output logic              overflow_o
);

  logic [EntryW-1:0] mem_q [FifoDepth];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              pop, full, accept;

  always_comb begin
    pop    = pop_i && (count_q != 2'd0);
    full   = (count_q == 2'(FifoDepth));
    // A pop in the same clock frees a slot, so a push into a full FIFO still lands.
    accept = push_i && (!full || pop);
    count_d = count_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (pop) begin
      overflow_d = 1'b0;
    end else if (push_i && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/trap_capture.sv
// Captures guest Z80 I/O cycles that violate the I/O policy into a FIFO for the hypervisor.
// Define TRAP_CAPTURE_DATA_EN to also record OUT data in each entry.
module trap_capture
  import trap_capture_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  trap_capture_if.slave  bus
);

  logic [3:0]  sync1_q, sync2_q;
  logic        iorq_prev_q;
  logic        iorq_s, m1_s, wr_s;
  logic        unused_rd_s;
  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        dir_q, dir_d;
  logic        hit_q, hit_d;
  logic        push;
  logic [EntryW-1:0] entry, head;
  logic [1:0]  count;
  logic        overflow;
  logic [7:0]  head_data;
  logic [7:0]  rd_mux;
  logic [7:0]  hv_data_q;

  // Strobes are asynchronous to clk; bit order {iorq_n, m1_n, rd_n, wr_n}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      iorq_prev_q <= 1'b1;
    end else begin
      sync1_q     <= {bus.iorq_n, bus.m1_n, bus.rd_n, bus.wr_n};
      sync2_q     <= sync1_q;
      iorq_prev_q <= sync2_q[3];
    end
  end

  assign iorq_s      = sync2_q[3];
  assign m1_s        = sync2_q[2];
  assign unused_rd_s = sync2_q[1];
  assign wr_s        = sync2_q[0];

`ifdef TRAP_CAPTURE_DATA_EN
  logic [7:0] data_q, data_d;
  assign entry     = {dir_q, addr_q, dir_q ? data_q : 8'hFF};
  assign head_data = head[7:0];
`else
  logic unused_data;
  assign unused_data = ^bus.data;
  assign entry       = {dir_q, addr_q};
  assign head_data   = 8'hFF;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dir_d   = dir_q;
    hit_d   = hit_q;
    push    = 1'b0;
`ifdef TRAP_CAPTURE_DATA_EN
    data_d  = data_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (iorq_prev_q && !iorq_s && m1_s) begin
          state_d = StCycle;
          addr_d  = bus.addr;
          dir_d   = !wr_s;
          hit_d   = 1'b0;
`ifdef TRAP_CAPTURE_DATA_EN
          data_d  = 8'hFF;
`endif
        end
      end
      StCycle: begin
        if (bus.io_violation && !bus.trap_state) hit_d = 1'b1;
`ifdef TRAP_CAPTURE_DATA_EN
        if (!wr_s) data_d = bus.data;
`endif
        if (iorq_s && !iorq_prev_q) state_d = StCommit;
      end
      StCommit: begin
        push    = hit_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= 16'h0000;
      dir_q   <= 1'b0;
      hit_q   <= 1'b0;
`ifdef TRAP_CAPTURE_DATA_EN
      data_q  <= 8'hFF;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      hit_q   <= hit_d;
`ifdef TRAP_CAPTURE_DATA_EN
      data_q  <= data_d;
`endif
    end
  end

  trap_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .entry_i    (entry),
    .pop_i      (bus.hv_ack),
    .head_o     (head),
    .count_o    (count),
    .overflow_o (overflow)
  );

  always_comb begin
    rd_mux = 8'hFF;
    unique case (bus.hv_sel)
      REG_STATUS: rd_mux = {count != 2'd0, overflow, (count != 2'd0) && head[EntryW-1],
                            3'b000, count};
      REG_ADDR_LO: if (count != 2'd0) rd_mux = head[EntryW-10 -: 8];
      REG_ADDR_HI: if (count != 2'd0) rd_mux = head[EntryW-2 -: 8];
      REG_DATA:    if (count != 2'd0) rd_mux = head_data;
      default:     rd_mux = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hv_data_q <= 8'hFF;
    end else if (bus.hv_rd) begin
      hv_data_q <= rd_mux;
    end
  end

  assign bus.hv_data  = hv_data_q;
  assign bus.pending  = (count != 2'd0);
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_trap_capture.sv
// Self-checking bench for trap_capture: directed scenarios plus randomized traffic vs a queue model.
module tb_trap_capture;
  import trap_capture_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_capture_if bus ();

  trap_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        dir;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t mq[$];
  bit  m_ov;
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model_push(input ev_t e);
    if (mq.size() == 2) m_ov = 1'b1;
    else mq.push_back(e);
  endfunction

  function automatic logic [7:0] model_reg(input int sel);
    logic [7:0] r;
    r = 8'hFF;
    case (sel)
      0: r = {mq.size() != 0, m_ov, (mq.size() != 0) ? mq[0].dir : 1'b0, 3'b000,
              2'(mq.size())};
      1: if (mq.size() != 0) r = mq[0].addr[7:0];
      2: if (mq.size() != 0) r = mq[0].addr[15:8];
      3: begin
`ifdef TRAP_CAPTURE_DATA_EN
        if (mq.size() != 0) r = mq[0].dir ? mq[0].data : 8'hFF;
`endif
      end
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input bit wr,
                           input bit viol, input bit trap, input bit irq_ack);
    ev_t e;
    @(negedge clk);
    bus.addr = a;
    bus.data = d;
    bus.io_violation = viol;
    bus.trap_state = trap;
    bus.m1_n = !irq_ack;
    bus.iorq_n = 1'b0;
    if (!irq_ack) begin
      if (wr) bus.wr_n = 1'b0;
      else bus.rd_n = 1'b0;
    end
    repeat (6) @(negedge clk);
    bus.iorq_n = 1'b1;
    bus.wr_n = 1'b1;
    bus.rd_n = 1'b1;
    bus.m1_n = 1'b1;
    repeat (6) @(negedge clk);
    bus.io_violation = 1'b0;
    bus.trap_state = 1'b0;
    if (!irq_ack && viol && !trap) begin
      e.dir = wr;
      e.addr = a;
      e.data = d;
      model_push(e);
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.hv_ack = 1'b1;
    @(negedge clk);
    bus.hv_ack = 1'b0;
    if (mq.size() != 0) begin
      void'(mq.pop_front());
      m_ov = 1'b0;
    end
  endtask

  task automatic hv_read(input logic [1:0] sel, output logic [7:0] v);
    @(negedge clk);
    bus.hv_rd = 1'b1;
    bus.hv_sel = sel;
    @(negedge clk);
    bus.hv_rd = 1'b0;
    v = bus.hv_data;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] v;
    for (int s = 0; s < 4; s++) begin
      hv_read(2'(s), v);
      check_eq($sformatf("%s_sel%0d", tag, s), {24'h0, v}, {24'h0, model_reg(s)});
    end
    check_eq({tag, "_pending"}, {31'h0, bus.pending}, {31'h0, mq.size() != 0});
    check_eq({tag, "_overflow"}, {31'h0, bus.overflow}, {31'h0, m_ov});
  endtask

  logic [7:0] v;
  logic [7:0] exp_d;

  initial begin
    bus.iorq_n = 1'b1; bus.m1_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    bus.addr = 16'h0; bus.data = 8'h0; bus.io_violation = 1'b0; bus.trap_state = 1'b0;
    bus.hv_rd = 1'b0; bus.hv_sel = 2'd0; bus.hv_ack = 1'b0;
    m_ov = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_hv_data", {24'h0, bus.hv_data}, 32'hFF);
    check_eq("reset_pending", {31'h0, bus.pending}, 32'h0);
    check_eq("reset_overflow", {31'h0, bus.overflow}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Violating OUT to 0x00A0
    bus_cycle(16'h00A0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    hv_read(2'd0, v); check_eq("out_sel0", {24'h0, v}, 32'hA1);
    hv_read(2'd1, v); check_eq("out_sel1", {24'h0, v}, 32'hA0);
    hv_read(2'd2, v); check_eq("out_sel2", {24'h0, v}, 32'h00);
`ifdef TRAP_CAPTURE_DATA_EN
    exp_d = 8'h5A;
`else
    exp_d = 8'hFF;
`endif
    hv_read(2'd3, v); check_eq("out_sel3", {24'h0, v}, {24'h0, exp_d});
    do_ack();
    check_eq("out_acked_pending", {31'h0, bus.pending}, 32'h0);

    // Suppressed cycles: trap active, no violation, interrupt acknowledge
    bus_cycle(16'h00A0, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("trap_state_nopush", {31'h0, bus.pending}, 32'h0);
    bus_cycle(16'h00A0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("noviol_nopush", {31'h0, bus.pending}, 32'h0);
    bus_cycle(16'h0038, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("irqack_nopush", {31'h0, bus.pending}, 32'h0);

    // Three violating INs overflow the two-entry FIFO
    bus_cycle(16'h0010, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    bus_cycle(16'h0011, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    bus_cycle(16'h0012, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    hv_read(2'd0, v); check_eq("ovf_sel0", {24'h0, v}, 32'hC2);
    hv_read(2'd1, v); check_eq("ovf_head", {24'h0, v}, 32'h10);
    hv_read(2'd3, v); check_eq("in_data_ff", {24'h0, v}, 32'hFF);
    do_ack();
    hv_read(2'd0, v); check_eq("ovf_ack_sel0", {24'h0, v}, 32'h81);
    hv_read(2'd1, v); check_eq("ovf_ack_head", {24'h0, v}, 32'h11);
    do_ack();

    // Ack on empty FIFO is ignored
    do_ack();
    hv_read(2'd0, v); check_eq("empty_ack_sel0", {24'h0, v}, 32'h00);
    hv_read(2'd1, v); check_eq("empty_sel1", {24'h0, v}, 32'hFF);

    // Reset in the middle of a violating cycle drops it
    @(negedge clk);
    bus.addr = 16'h0055; bus.data = 8'h33; bus.io_violation = 1'b1;
    bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.iorq_n = 1'b1; bus.wr_n = 1'b1; bus.io_violation = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ov = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("rst_mid_pending", {31'h0, bus.pending}, 32'h0);
    hv_read(2'd1, v); check_eq("rst_mid_sel1", {24'h0, v}, 32'hFF);

    // Randomized traffic against the queue model
    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 3));
      if (op <= 1) begin
        bus_cycle(16'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      end else if (op == 2) begin
        do_ack();
      end
      check_all($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_capture.md
TRAP_CAPTURE -- requirements
Module: trap_capture

Interface
REQ-001 SHALL have these ports: clk, input, 1, single system clock; all state is on its rising edge.
REQ-002 SHALL have: rst, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have: iorq_n, m1_n, rd_n, wr_n, input, 1 each, raw Z80 bus strobes, asynchronous to clk.
REQ-004 SHALL have: addr, input, 16, Z80 address bus; data, input, 8, Z80 data bus.
REQ-005 SHALL have: io_violation, input, 1, decoded "guest I/O address not permitted"; trap_state, input, 1, hypervisor trap active.
REQ-006 SHALL have: hv_rd, input, 1, one-clk hypervisor register read strobe; hv_sel, input, 2, register index; hv_ack, input, 1, one-clk pop strobe.
REQ-007 SHALL have: hv_data, output, 8, register readback; pending, output, 1, FIFO non-empty; overflow, output, 1, sticky lost-event flag.

Function
REQ-008 SHALL synchronise iorq_n, m1_n, rd_n and wr_n through two flops each; all decisions use the synchronised copies.
REQ-009 SHALL use FSM IDLE -> CYCLE -> COMMIT -> IDLE.
REQ-010 IDLE -> CYCLE on a synchronised iorq_n falling edge with m1_n high; iorq_n falling with m1_n low (interrupt acknowledge) SHALL be ignored.
REQ-011 On CYCLE entry SHALL latch addr, direction (1 = write when wr_n low, else read), and clear hit flag.
REQ-012 In CYCLE, SHALL set hit when io_violation high and trap_state low; write data SHALL be sampled every CYCLE clock while wr_n low (last sample wins).
REQ-013 CYCLE -> COMMIT on iorq_n rising; COMMIT SHALL push {dir, addr, data} when hit set, then return to IDLE next clock; hit clear SHALL return without push.
REQ-014 FIFO SHALL be 2 entries, 25 bits each, with 1-bit read/write pointers wrapping modulo 2 and 2-bit count.
REQ-015 Push while full SHALL discard the new entry, keep existing entries, set overflow.
REQ-016 hv_ack while non-empty SHALL pop the head; hv_ack while empty SHALL be ignored; hv_ack with count 0 does not clear overflow.
REQ-017 Simultaneous push and pop when full SHALL pop head and accept the push (count stays 2, no overflow).
REQ-018 hv_ack while count is 1 or 2 and overflow set SHALL clear overflow after the pop.
REQ-019 hv_data SHALL be registered, updated one clk after hv_rd: sel 0 = {pending, overflow, dir, 3'b0, count}; 1 = head addr[7:0]; 2 = head addr[15:8]; 3 = head data.
REQ-020 With FIFO empty, sel 1-3 SHALL return 8'hFF.
REQ-021 pending SHALL equal (count != 0), combinational from count.
REQ-022 A read-direction entry SHALL store data as 8'hFF.

Reset
REQ-023 rst SHALL force FSM IDLE, count 0, pointers 0, overflow 0, hv_data 8'hFF, sync flops to 1 (strobes inactive).
REQ-024 rst asserted mid-CYCLE SHALL drop the in-flight cycle without a push.

Configuration
REQ-025 With TRAP_CAPTURE_DATA_EN defined, write data SHALL be captured per REQ-012; without it the data field SHALL not be stored and sel 3 SHALL always return 8'hFF (entry width 17 bits).

Structure
REQ-026 Shared package SHALL hold FSM state encoding, register index constants (REG_STATUS, REG_ADDR_LO, REG_ADDR_HI, REG_DATA), FIFO depth 2 and entry width.
REQ-027 FIFO storage and pointers SHALL be a sub-module named trap_fifo; sync, FSM and readback stay in trap_capture.

Verification
REQ-028 Guest OUT to 0x00A0 data 0x5A, io_violation=1, trap_state=0 -> pending=1; sel0=0xA1, sel1=0xA0, sel2=0x00, sel3=0x5A.
REQ-029 Same OUT with trap_state=1, or io_violation=0 -> no push, pending stays 0.
REQ-030 iorq_n low with m1_n low (IRQ ack), io_violation=1 -> no push.
REQ-031 Three violating IN cycles at 0x10,0x11,0x12 without ack -> count 2, overflow=1, head addr 0x10; one hv_ack -> head 0x11, overflow=0, count 1.
REQ-032 hv_ack on empty FIFO -> count 0, sel1 returns 0xFF; rst mid-CYCLE -> no entry after release.
REQ-033 Build without TRAP_CAPTURE_DATA_EN, violating OUT data 0x5A -> sel3 returns 0xFF.
